// File: rtl/vec_pkg.sv
// Shared types for the serial vector link.
// The vector width is fixed by the link; both ends of the link import these types.
package vec_pkg;
    localparam int VEC_W = 8;

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
endpackage

// File: rtl/vector_ring.sv
// Ring of NB vectors addressed by wrap-bit pointers.
// Storage is deliberately left unreset; only the pointers are reset.
module vector_ring
    import vec_pkg::*;
#(
    parameter int NB = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic                pop,
    input  vec_t                wr_data,
    output vec_t                rd_data,
    output logic                full,
    output logic                empty,
    output logic [$clog2(NB):0] count
);
    localparam int PW = $clog2(NB) + 1;
    localparam int AW = PW - 1;

    vec_t          mem [NB];
    logic [PW-1:0] prod_q, prod_d;
    logic [PW-1:0] cons_q, cons_d;
    logic          wr_en, rd_en;

    // Full and empty come from pre-edge pointers, so a same-cycle pop never frees room for a push.
    assign full    = (prod_q ^ cons_q) == PW'(NB);
    assign empty   = prod_q == cons_q;
    assign count   = prod_q - cons_q;
    assign rd_data = mem[cons_q[AW-1:0]];
    assign wr_en   = push && !full;
    assign rd_en   = pop && !empty;

    always_comb begin
        prod_d = prod_q;
        cons_d = cons_q;
        if (wr_en) prod_d = prod_q + PW'(1);
        if (rd_en) cons_d = cons_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            cons_q <= '0;
        end else begin
            prod_q <= prod_d;
            cons_q <= cons_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[prod_q[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/vector_serializer.sv
// Transmit side of the serial vector link.
// Queues vectors in a ring and shifts them out MSB first under a valid/ready handshake.
module vector_serializer
    import vec_pkg::*;
#(
    parameter int NB_VECTORS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [VEC_W-1:0]            vector,
    input  logic                        push,
    output logic                        ready,
    output logic                        bit_out,
    output logic                        bit_valid,
    input  logic                        bit_ready,
    output logic [$clog2(NB_VECTORS):0] count,
    output logic                        empty,
    output logic                        overflow
);
    localparam int IW = $clog2(VEC_W);

    state_e        state_q, state_d;
    vec_t          shreg_q, shreg_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic          overflow_q, overflow_d;

    logic ring_full, ring_empty;
    vec_t ring_rd;
    logic xfer, last, load;

    vector_ring #(.NB(NB_VECTORS)) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (load),
        .wr_data (vector),
        .rd_data (ring_rd),
        .full    (ring_full),
        .empty   (ring_empty),
        .count   (count)
    );

    assign xfer = (state_q == SHIFT) && bit_ready;
    assign last = bit_idx_q == IW'(VEC_W - 1);
    // Reloading on the last bit's transfer keeps back-to-back vectors free of bubbles.
    assign load = !ring_empty && ((state_q == IDLE) || (xfer && last));

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        overflow_d = overflow_q || (push && ring_full);
        if (load) begin
            state_d   = SHIFT;
            shreg_d   = ring_rd;
            bit_idx_d = '0;
        end else if (xfer) begin
            shreg_d   = shreg_q << 1;
            bit_idx_d = bit_idx_q + IW'(1);
            if (last) state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            overflow_q <= overflow_d;
        end
    end

    assign ready     = !ring_full;
    assign bit_valid = state_q == SHIFT;
    assign bit_out   = bit_valid ? shreg_q[VEC_W-1] : 1'b0;
    assign empty     = (count == '0) && (state_q == IDLE);
    assign overflow  = overflow_q;
endmodule
